// File: rtl/if_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
// Provides the fetch FSM states, the instr_sel codes, the next-PC select and a saturating-increment helper.
package if_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALT   = 2'd2,
    RESUME = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_TGT  = 2'd2
  } pc_sel_e;

  localparam logic [1:0]  ISEL_PASS   = 2'b00;
  localparam logic [1:0]  ISEL_REPLAY = 2'b01;
  localparam logic [1:0]  ISEL_KILL   = 2'b10;
  localparam logic [31:0] RV_NOP      = 32'h0000_0013;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/if_perf_cnt.sv
// Fetch performance counters: pass, replay and accepted-redirect cycles, each saturating at 2^32-1.
// Counts appear one cycle after the qualifying fetch cycle.
module if_perf_cnt
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_fetch,
  input  logic        inc_stall,
  input  logic        inc_redirect,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_redirect
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch    <= '0;
      perf_stall    <= '0;
      perf_redirect <= '0;
    end else begin
      perf_fetch    <= sat_inc(perf_fetch, inc_fetch);
      perf_stall    <= sat_inc(perf_stall, inc_stall);
      perf_redirect <= sat_inc(perf_redirect, inc_redirect);
    end
  end

endmodule

// File: rtl/if_stage.sv
// RV32I fetch: owns PC, drives the 1-cycle instruction SRAM (im_addr = next PC), pc_if one cycle later.
// load_use holds and replays; halt stops the SRAM. Perf counters exist only when IF_PERF_EN is defined.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_use,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic [31:0]       target,
  input  logic              halt_req,
  output logic              halted,
  output logic              im_ce,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       pc_if,
  output logic [1:0]        instr_sel,
  output logic              fetch_misalign,
  output logic [31:0]       perf_fetch,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_redirect
);

  fetch_state_e state_q, state_nxt;
  pc_sel_e      pc_sel;
  logic [31:0]  pc_q, pc_nxt;
  logic         redirect, redirect_acc, misalign_q;

  assign redirect = branch_taken | jump;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      pc_q       <= pc_nxt;
      misalign_q <= redirect_acc && (target[1:0] != 2'b00);
    end
  end

  // load_use blocks halt entry so the replayed instruction is not lost
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      BOOT:    state_nxt = RUN;
      RUN:     if (halt_req && !load_use) state_nxt = HALT;
      HALT:    if (!halt_req) state_nxt = RESUME;
      RESUME:  state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    im_ce        = 1'b1;
    pc_sel       = PC_HOLD;
    instr_sel    = ISEL_KILL;
    redirect_acc = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect) begin
          pc_sel       = PC_TGT;
          redirect_acc = 1'b1;
        end else if (load_use) begin
          instr_sel = ISEL_REPLAY;
        end else if (!halt_req) begin
          pc_sel    = PC_INC;
          instr_sel = ISEL_PASS;
        end
      end
      HALT:    im_ce = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    pc_nxt = pc_q;
    case (pc_sel)
      PC_INC:  pc_nxt = pc_q + 32'd4;
      PC_TGT:  pc_nxt = {target[31:2], 2'b00};
      default: pc_nxt = pc_q;
    endcase
  end

  assign im_addr        = pc_nxt[ADDR_W-1:0];
  assign pc_if          = pc_q;
  assign halted         = (state_q == HALT);
  assign fetch_misalign = misalign_q;

`ifdef IF_PERF_EN
  if_perf_cnt u_perf (
    .clk           (clk),
    .rst           (rst),
    .inc_fetch     ((state_q == RUN) && (instr_sel == ISEL_PASS)),
    .inc_stall     ((state_q == RUN) && (instr_sel == ISEL_REPLAY)),
    .inc_redirect  (redirect_acc),
    .perf_fetch    (perf_fetch),
    .perf_stall    (perf_stall),
    .perf_redirect (perf_redirect)
  );
`else
  assign perf_fetch    = '0;
  assign perf_stall    = '0;
  assign perf_redirect = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: boot, straight line, load_use, jump/branch redirect, misalign, halt/resume, mid-halt reset.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        load_use, branch_taken, jump, halt_req;
  logic [31:0] target;
  logic        halted, im_ce, fetch_misalign;
  logic [15:0] im_addr;
  logic [31:0] pc_if;
  logic [1:0]  instr_sel;
  logic [31:0] perf_fetch, perf_stall, perf_redirect;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000), .ADDR_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .load_use       (load_use),
    .branch_taken   (branch_taken),
    .jump           (jump),
    .target         (target),
    .halt_req       (halt_req),
    .halted         (halted),
    .im_ce          (im_ce),
    .im_addr        (im_addr),
    .pc_if          (pc_if),
    .instr_sel      (instr_sel),
    .fetch_misalign (fetch_misalign),
    .perf_fetch     (perf_fetch),
    .perf_stall     (perf_stall),
    .perf_redirect  (perf_redirect)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic [31:0] pc, input logic [31:0] addr,
                        input logic [1:0] sel);
    chk({tag, ".pc_if"}, pc_if, pc);
    chk({tag, ".im_addr"}, {16'h0, im_addr}, addr);
    chk({tag, ".instr_sel"}, {30'h0, instr_sel}, {30'h0, sel});
  endtask

  task automatic chk_perf(input string tag, input logic [31:0] f, input logic [31:0] s,
                          input logic [31:0] r);
`ifdef IF_PERF_EN
    chk({tag, ".perf_fetch"}, perf_fetch, f);
    chk({tag, ".perf_stall"}, perf_stall, s);
    chk({tag, ".perf_redirect"}, perf_redirect, r);
`else
    chk({tag, ".perf_fetch"}, perf_fetch, 32'h0);
    chk({tag, ".perf_stall"}, perf_stall, 32'h0);
    chk({tag, ".perf_redirect"}, perf_redirect, 32'h0);
`endif
  endtask

  // Advance to just after the next rising edge, then apply this cycle's inputs and let them settle.
  task automatic cyc(input logic lu, input logic br, input logic jp, input logic [31:0] tg,
                     input logic hr);
    @(posedge clk);
    #1;
    load_use = lu; branch_taken = br; jump = jp; target = tg; halt_req = hr;
    #1;
  endtask

  initial begin
    rst = 1'b1; load_use = 1'b0; branch_taken = 1'b0; jump = 1'b0; halt_req = 1'b0;
    target = 32'h0;
    #12;
    chk_if("reset", 32'h0, 32'h0, 2'b10);
    chk("reset.halted", {31'h0, halted}, 32'h0);
    chk("reset.misalign", {31'h0, fetch_misalign}, 32'h0);
    chk("reset.im_ce", {31'h0, im_ce}, 32'h1);
    chk_perf("reset", 32'h0, 32'h0, 32'h0);

    @(negedge clk); rst = 1'b0; #1;
    chk_if("boot", 32'h0, 32'h0, 2'b10);

    cyc(0, 0, 0, 32'h0, 0);  chk_if("c1", 32'h0, 32'h4, 2'b00);
    cyc(0, 0, 0, 32'h0, 0);  chk_if("c2", 32'h4, 32'h8, 2'b00);
    cyc(1, 0, 0, 32'h0, 0);  chk_if("c3_load_use", 32'h8, 32'h8, 2'b01);
    cyc(0, 0, 0, 32'h0, 0);  chk_if("c4_replayed", 32'h8, 32'hC, 2'b00);
    cyc(0, 0, 1, 32'h100, 0); chk_if("c5_jump", 32'hC, 32'h100, 2'b10);
    cyc(1, 1, 0, 32'h40, 0); chk_if("c6_br_lu", 32'h100, 32'h40, 2'b10);
    // passes: c1,c2,c4; replay: c3; redirects: c5,c6
    cyc(0, 1, 0, 32'h102, 0); chk_if("c7_br_misal", 32'h40, 32'h100, 2'b10);
    chk("c7.misalign", {31'h0, fetch_misalign}, 32'h0);
    chk_perf("c7", 32'h3, 32'h1, 32'h2);
    cyc(0, 0, 1, 32'h20, 0); chk_if("c8_jump20", 32'h100, 32'h20, 2'b10);
    chk("c8.misalign", {31'h0, fetch_misalign}, 32'h1);
    cyc(0, 0, 0, 32'h0, 1);  chk_if("c9_halt_req", 32'h20, 32'h20, 2'b10);
    chk("c9.misalign", {31'h0, fetch_misalign}, 32'h0);
    chk("c9.halted", {31'h0, halted}, 32'h0);

    // Redirect during HALT must be ignored.
    cyc(0, 0, 1, 32'h80, 1); chk_if("c10_halt", 32'h20, 32'h20, 2'b10);
    chk("c10.halted", {31'h0, halted}, 32'h1);
    chk("c10.im_ce", {31'h0, im_ce}, 32'h0);
    chk_perf("c10", 32'h3, 32'h1, 32'h4);
    cyc(0, 0, 0, 32'h0, 0);  chk_if("c11_release", 32'h20, 32'h20, 2'b10);
    chk("c11.halted", {31'h0, halted}, 32'h1);
    chk("c11.im_ce", {31'h0, im_ce}, 32'h0);
    cyc(0, 0, 0, 32'h0, 0);  chk_if("c12_resume", 32'h20, 32'h20, 2'b10);
    chk("c12.halted", {31'h0, halted}, 32'h0);
    chk("c12.im_ce", {31'h0, im_ce}, 32'h1);
    cyc(0, 0, 0, 32'h0, 1);  chk_if("c13_run_halt", 32'h20, 32'h20, 2'b10);
    cyc(0, 0, 0, 32'h0, 0);
    chk("c14.halted", {31'h0, halted}, 32'h1);

    rst = 1'b1; #1;
    chk_if("rst_mid_halt", 32'h0, 32'h0, 2'b10);
    chk("rst_mid_halt.halted", {31'h0, halted}, 32'h0);
    chk("rst_mid_halt.im_ce", {31'h0, im_ce}, 32'h1);
    chk_perf("rst_mid_halt", 32'h0, 32'h0, 32'h0);
    rst = 1'b0; #1;
    chk_if("post_rst_boot", 32'h0, 32'h0, 2'b10);
    cyc(0, 0, 0, 32'h0, 0);  chk_if("post_rst_run", 32'h0, 32'h4, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
